// File: rtl/mult_reconstructor.sv
// rtl/mult_reconstructor.sv - sequential signed multiply-accumulate rebuilding Num = Coc*Den + Res
module mult_reconstructor #(
  parameter int tamanyo = 32
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic                   Start,
  input  logic [tamanyo-1:0]     Coc,
  input  logic [tamanyo-1:0]     Den,
  input  logic [tamanyo-1:0]     Res,
  output logic                   Ready,
  output logic [tamanyo-1:0]     Num,
  output logic [2*tamanyo-1:0]   Prod,
  output logic                   Overflow,
  output logic                   Done
);

  localparam int W2 = 2 * tamanyo;
  localparam int CW = (tamanyo > 2) ? $clog2(tamanyo) : 1;

  typedef enum logic [1:0] {IDLE, MULT, FIX} state_t;

  state_t             state, state_n;
  logic               s_c, s_d;
  logic [tamanyo-1:0] res_r;
  logic [tamanyo-1:0] mplier;
  logic [W2-1:0]      mcand;
  logic [W2-1:0]      acc;
  logic [CW-1:0]      cnt;

  logic [tamanyo-1:0] mag_c, mag_d;
  logic [W2-1:0]      prod_n;
  logic               ovf_n;

  // Magnitudes as unsigned; the most negative value maps onto 2^(n-1) without saturating.
  assign mag_c = Coc[tamanyo-1] ? (~Coc + 1'b1) : Coc;
  assign mag_d = Den[tamanyo-1] ? (~Den + 1'b1) : Den;

  assign prod_n = ((s_c ^ s_d) ? (~acc + 1'b1) : acc)
                + {{tamanyo{res_r[tamanyo-1]}}, res_r};
  assign ovf_n  = !((&prod_n[W2-1:tamanyo-1]) || !(|prod_n[W2-1:tamanyo-1]));

  assign Ready = (state == IDLE);

  always_ff @(posedge CLK) begin
    if (RSTa) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (Start) state_n = MULT;
      MULT:    if (cnt == CW'(tamanyo - 1)) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RSTa) begin
      s_c      <= 1'b0;
      s_d      <= 1'b0;
      res_r    <= '0;
      mplier   <= '0;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      Num      <= '0;
      Prod     <= '0;
      Overflow <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            s_c    <= Coc[tamanyo-1];
            s_d    <= Den[tamanyo-1];
            res_r  <= Res;
            mplier <= mag_c;
            mcand  <= {{tamanyo{1'b0}}, mag_d};
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MULT: begin
          // Multiplicand is pre-shifted each step, equivalent to adding mag_d << cnt.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        FIX: begin
          Prod     <= prod_n;
          Num      <= prod_n[tamanyo-1:0];
          Overflow <= ovf_n;
          Done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_reconstructor.sv
// tb/tb_mult_reconstructor.sv - directed table-driven bench for mult_reconstructor
module tb_mult_reconstructor;

  logic        CLK;
  logic        RSTa;
  logic        Start;
  logic [31:0] Coc, Den, Res;
  logic        Ready;
  logic [31:0] Num;
  logic [63:0] Prod;
  logic        Overflow;
  logic        Done;

  int checks   = 0;
  int failures = 0;

  mult_reconstructor #(.tamanyo(32)) dut (
    .CLK(CLK), .RSTa(RSTa), .Start(Start),
    .Coc(Coc), .Den(Den), .Res(Res),
    .Ready(Ready), .Num(Num), .Prod(Prod),
    .Overflow(Overflow), .Done(Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] coc;
    logic [31:0] den;
    logic [31:0] res;
    logic [31:0] num;
    logic [63:0] prod;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Counts edges after the accepting edge until Done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (Done !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int n);
    check({tag, " latency"}, 64'(n), 64'd33);
    check({tag, " ready_with_done"}, 64'(Ready), 64'd1);
    check({tag, " num"}, 64'(Num), 64'(v.num));
    check({tag, " prod"}, Prod, v.prod);
    check({tag, " ovf"}, 64'(Overflow), 64'(v.ovf));
    @(negedge CLK);
    check({tag, " done_one_cycle"}, 64'(Done), 64'd0);
    check({tag, " num_hold"}, 64'(Num), 64'(v.num));
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int n;
    @(negedge CLK);
    Coc = v.coc; Den = v.den; Res = v.res; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    check({tag, " busy"}, 64'(Ready), 64'd0);
    wait_done(n);
    check_result(tag, v, n);
  endtask

  initial begin
    int n;
    vec_t va, vb;

    vecs[0] = '{32'd3,        32'd2,        32'd1,        32'd7,        64'd7,                  1'b0};
    vecs[1] = '{32'hFFFFFFFD, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFF9, 64'hFFFFFFFFFFFFFFF9,   1'b0};
    vecs[2] = '{32'd3,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 64'hFFFFFFFFFFFFFFF9,   1'b0};
    vecs[3] = '{32'd5,        32'd0,        32'd9,        32'd9,        64'd9,                  1'b0};
    vecs[4] = '{32'h7FFFFFFF, 32'd1,        32'd0,        32'h7FFFFFFF, 64'h000000007FFFFFFF,   1'b0};
    vecs[5] = '{32'h00010000, 32'h00010000, 32'd0,        32'd0,        64'h0000000100000000,   1'b1};
    vecs[6] = '{32'h80000000, 32'h80000000, 32'd0,        32'd0,        64'h4000000000000000,   1'b1};
    vecs[7] = '{32'h80000000, 32'd1,        32'd0,        32'h80000000, 64'hFFFFFFFF80000000,   1'b0};
    vecs[8] = '{32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h7FFFFFFF, 64'hFFFFFFFF7FFFFFFF,   1'b1};
    vecs[9] = '{32'h7FFFFFFF, 32'd1,        32'd1,        32'h80000000, 64'h0000000080000000,   1'b1};

    RSTa = 1'b1; Start = 1'b0; Coc = '0; Den = '0; Res = '0;
    repeat (2) @(negedge CLK);
    RSTa = 1'b0;
    check("reset ready", 64'(Ready), 64'd1);
    check("reset done", 64'(Done), 64'd0);
    check("reset num", 64'(Num), 64'd0);
    check("reset prod", Prod, 64'd0);
    check("reset ovf", 64'(Overflow), 64'd0);

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Start during busy and operand changes after acceptance are ignored.
    va = vecs[0];
    @(negedge CLK);
    Coc = va.coc; Den = va.den; Res = va.res; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    Coc = 32'd100; Den = 32'd100; Res = 32'd5;
    repeat (9) @(negedge CLK);
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    n = 10;
    while (Done !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check_result("ignore", va, n);

    // Start held high through Done: second op accepted at the Done edge.
    va = vecs[3];
    vb = vecs[1];
    @(negedge CLK);
    Coc = va.coc; Den = va.den; Res = va.res; Start = 1'b1;
    @(negedge CLK);
    Coc = vb.coc; Den = vb.den; Res = vb.res;
    wait_done(n);
    check("b2b first latency", 64'(n), 64'd33);
    check("b2b first num", 64'(Num), 64'(va.num));
    @(negedge CLK);
    Start = 1'b0;
    check("b2b second busy", 64'(Ready), 64'd0);
    wait_done(n);
    check_result("b2b second", vb, n);

    // Reset mid-MULT discards the operation.
    va = vecs[6];
    @(negedge CLK);
    Coc = va.coc; Den = va.den; Res = va.res; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (14) @(negedge CLK);
    RSTa = 1'b1;
    @(negedge CLK);
    RSTa = 1'b0;
    check("midreset ready", 64'(Ready), 64'd1);
    check("midreset num", 64'(Num), 64'd0);
    check("midreset prod", Prod, 64'd0);
    check("midreset ovf", 64'(Overflow), 64'd0);
    check("midreset done", 64'(Done), 64'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (Done === 1'b1) n++;
    end
    check("midreset no_done", 64'(n), 64'd0);
    run_vec("after_reset", vecs[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
